// File: rtl/boothmul_pkg.sv
// boothmul_pkg
//   Shared types and helpers for the pipelined radix-2 Booth multiplier.
//   booth_op_t       : recoded action for one multiplier bit pair
//   booth_decode()   : maps {x[i], x[i-1]} to a booth_op_t
//   boothmul_latency : input-accept to output-valid distance in cycles
package boothmul_pkg;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

    // Operand register, WIDTH+1 Booth steps, then the output register.
    function automatic int boothmul_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step
//   One Booth recoding stage of boothmul_pipe. Looks at the two low bits of
//   the pre-shifted multiplier ({x[STEP], x[STEP-1]}), adds or subtracts the
//   multiplicand weighted by 2^STEP into the partial sum, and registers
//   everything for the next stage. All registers hold while adv is low.
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   adv               global pipeline advance
//   validIn/validOut  stage occupancy
//   tagIn/tagOut      per-operation accumulate tag, carried untouched
//   mcandIn/Out       multiplicand, already extended to WIDTH+1 bits
//   mplierIn/Out      multiplier with x[-1]=0 appended, shifted right per stage
//   psumIn/Out        2*WIDTH+2 bit partial sum
module booth_step
    import boothmul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 validIn,
    input  logic                 tagIn,
    input  logic [WIDTH:0]       mcandIn,
    input  logic [WIDTH+1:0]     mplierIn,
    input  logic [2*WIDTH+1:0]   psumIn,
    output logic                 validOut,
    output logic                 tagOut,
    output logic [WIDTH:0]       mcandOut,
    output logic [WIDTH+1:0]     mplierOut,
    output logic [2*WIDTH+1:0]   psumOut
);

    localparam int PW = 2*WIDTH + 2;

    booth_op_t       op;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   psumNext;

    // The extended multiplicand is already in two's complement form for both
    // modes, so plain sign extension to the partial-sum width is correct.
    assign addend = {{(PW-WIDTH-1){mcandIn[WIDTH]}}, mcandIn} << STEP;
    assign op     = booth_decode(mplierIn[1:0]);

    always_comb begin
        psumNext = psumIn;
        case (op)
            BOOTH_ADD: psumNext = psumIn + addend;
            BOOTH_SUB: psumNext = psumIn - addend;
            default:   psumNext = psumIn;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validOut  <= 1'b0;
            tagOut    <= 1'b0;
            mcandOut  <= '0;
            mplierOut <= '0;
            psumOut   <= '0;
        end else if (adv) begin
            validOut  <= validIn;
            tagOut    <= tagIn;
            mcandOut  <= mcandIn;
            mplierOut <= mplierIn >> 1;
            psumOut   <= psumNext;
        end
    end

endmodule

// File: rtl/boothmul_pipe.sv
// boothmul_pipe
//   Fully pipelined radix-2 Booth multiplier, one operation per cycle.
//   Per-operation signed/unsigned mode, valid/ready handshake with a single
//   global advance that stalls the whole pipeline, results in issue order.
//   Latency WIDTH+2 cycles from acceptance to out_valid.
//   Optional build macro BOOTHMUL_ACC_EN adds the in_acc port and an
//   accumulator that sums results modulo 2^(2*WIDTH).
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is the global advance
//   in_signed            1: both operands two's complement, 0: both unsigned
//   w2mul                multiplicand
//   x2mul                multiplier (Booth-recoded operand)
//   in_acc               accumulate tag (BOOTHMUL_ACC_EN only)
//   out_valid/out_ready  result handshake
//   mul2acc              product, or running sum when accumulating
module boothmul_pipe
    import boothmul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   w2mul,
    input  logic [WIDTH-1:0]   x2mul,
`ifdef BOOTHMUL_ACC_EN
    input  logic               in_acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] mul2acc
);

    localparam int LATENCY = boothmul_latency(WIDTH);
    localparam int NSTEPS  = LATENCY - 1;
    localparam int PW      = 2*WIDTH + 2;

    logic                adv;
    logic                accTag;

    logic                validChain  [0:NSTEPS];
    logic                tagChain    [0:NSTEPS];
    logic [WIDTH:0]      mcandChain  [0:NSTEPS];
    logic [WIDTH+1:0]    mplierChain [0:NSTEPS];
    logic [PW-1:0]       psumChain   [0:NSTEPS];

    logic                s0Valid;
    logic                s0Tag;
    logic [WIDTH:0]      s0Mcand;
    logic [WIDTH+1:0]    s0Mplier;

    logic                outValid;
    logic                outTag;
    logic [2*WIDTH-1:0]  outProd;
    logic                unusedTail;

    // Advance depends only on the output register and out_ready, so a
    // stalled consumer freezes every stage at once.
    assign adv       = out_ready | ~outValid;
    assign in_ready  = adv;
    assign out_valid = outValid;

`ifdef BOOTHMUL_ACC_EN
    assign accTag = in_acc;
`else
    assign accTag = 1'b0;
`endif

    // Stage 0: extend operands by one bit so that both modes become signed
    // (WIDTH+1)-bit arithmetic, and append x[-1]=0 below the multiplier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0Valid  <= 1'b0;
            s0Tag    <= 1'b0;
            s0Mcand  <= '0;
            s0Mplier <= '0;
        end else if (adv) begin
            s0Valid  <= in_valid;
            s0Tag    <= accTag;
            s0Mcand  <= {in_signed & w2mul[WIDTH-1], w2mul};
            s0Mplier <= {in_signed & x2mul[WIDTH-1], x2mul, 1'b0};
        end
    end

    assign validChain[0]  = s0Valid;
    assign tagChain[0]    = s0Tag;
    assign mcandChain[0]  = s0Mcand;
    assign mplierChain[0] = s0Mplier;
    assign psumChain[0]   = '0;

    for (genvar g = 0; g < NSTEPS; g++) begin : gStep
        booth_step #(
            .WIDTH (WIDTH),
            .STEP  (g)
        ) uStep (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .validIn   (validChain[g]),
            .tagIn     (tagChain[g]),
            .mcandIn   (mcandChain[g]),
            .mplierIn  (mplierChain[g]),
            .psumIn    (psumChain[g]),
            .validOut  (validChain[g+1]),
            .tagOut    (tagChain[g+1]),
            .mcandOut  (mcandChain[g+1]),
            .mplierOut (mplierChain[g+1]),
            .psumOut   (psumChain[g+1])
        );
    end

    // Output register: the only thing the consumer sees, so out_valid and
    // the product never depend combinationally on any input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outValid <= 1'b0;
            outTag   <= 1'b0;
            outProd  <= '0;
        end else if (adv) begin
            outValid <= validChain[NSTEPS];
            outTag   <= tagChain[NSTEPS];
            outProd  <= psumChain[NSTEPS][2*WIDTH-1:0];
        end
    end

`ifdef BOOTHMUL_ACC_EN
    logic [2*WIDTH-1:0] accQ;

    assign mul2acc = outTag ? (accQ + outProd) : outProd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accQ <= '0;
        end else if (outValid && out_ready) begin
            accQ <= mul2acc;
        end
    end

    assign unusedTail = ^{psumChain[NSTEPS][PW-1:2*WIDTH],
                          mcandChain[NSTEPS], mplierChain[NSTEPS]};
`else
    assign mul2acc = outProd;

    assign unusedTail = ^{psumChain[NSTEPS][PW-1:2*WIDTH],
                          mcandChain[NSTEPS], mplierChain[NSTEPS], outTag};
`endif

endmodule

// File: tb/tb_boothmul_pipe.sv
module tb_boothmul_pipe;

    localparam int W   = 4;
    localparam int LAT = W + 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic         in_acc;
    logic [W-1:0] w2mul;
    logic [W-1:0] x2mul;
    logic         out_valid;
    logic         out_ready;
    logic [2*W-1:0] mul2acc;

    int           nAsserts;
    int           nFails;
    logic         lastAcc;
    logic [2*W-1:0] modelAcc;
    logic [2*W-1:0] q[$];

    boothmul_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .w2mul     (w2mul),
        .x2mul     (x2mul),
`ifdef BOOTHMUL_ACC_EN
        .in_acc    (in_acc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mul2acc   (mul2acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] refMul(input logic s, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        int av;
        int bv;
        if (s) begin
            av = int'($signed(a));
            bv = int'($signed(b));
        end else begin
            av = int'(a);
            bv = int'(b);
        end
        return (2*W)'(av * bv);
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes at the negedge, then advance past the posedge.
    task automatic cycle();
        logic [2*W-1:0] p;
        logic [2*W-1:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            check("sb_nonempty", 8'(q.size() != 0), 8'd1);
            if (q.size() != 0) check("sb_result", mul2acc, q.pop_front());
        end
        lastAcc = in_valid && in_ready;
        if (lastAcc) begin
            p = refMul(in_signed, w2mul, x2mul);
            e = in_acc ? modelAcc + p : p;
            modelAcc = e;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic acc);
        in_valid  = 1'b1;
        in_signed = s;
        w2mul     = a;
        x2mul     = b;
        in_acc    = acc;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        in_acc    = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + 4) cycle();
        check("drain_empty", 8'(q.size()), 8'd0);
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            cycle();
            n++;
        end
        check(tag, 8'(out_valid), 8'd1);
    endtask

    initial begin
        int cnt;
        nAsserts  = 0;
        nFails    = 0;
        lastAcc   = 1'b0;
        modelAcc  = '0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_acc    = 1'b0;
        w2mul     = '0;
        x2mul     = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_mul2acc", mul2acc, 8'h00);
        check("rst_in_ready", 8'(in_ready), 8'd1);
        rst = 1'b1;
        cycle();

        // Latency: signed -8 x -8
        drive(1'b1, 4'h8, 4'h8, 1'b0);
        cycle();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            cycle();
            cnt++;
        end
        check("latency", 8'(cnt), 8'(LAT));
        check("neg8_sq", mul2acc, 8'h40);
        drain();

        // Back-to-back mixed modes
        drive(1'b0, 4'hF, 4'hF, 1'b0);
        cycle();
        drive(1'b1, 4'h7, 4'h8, 1'b0);
        cycle();
        in_valid = 1'b0;
        waitValid("b2b_wait");
        check("b2b_first", mul2acc, 8'hE1);
        cycle();
        check("b2b_second_valid", 8'(out_valid), 8'd1);
        check("b2b_second", mul2acc, 8'hC8);
        drain();

        // Exhaustive sweep, modes interleaved per operation, full rate
        for (int i = 0; i < 512; i++) begin
            drive(i[0], i[8:5], i[4:1], 1'b0);
            cycle();
        end
        drain();

        // Random traffic with random back-pressure; source holds until taken
        lastAcc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || lastAcc) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_signed = 1'($urandom_range(0, 1));
                w2mul     = W'($urandom);
                x2mul     = W'($urandom);
`ifdef BOOTHMUL_ACC_EN
                in_acc    = 1'($urandom_range(0, 1));
`endif
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        // Stall with a full pipeline
        for (int k = 0; k < 10; k++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0);
            cycle();
        end
        out_ready = 1'b0;
        drive(1'b0, 4'h9, 4'hB, 1'b0);
        cycle();
        for (int k = 0; k < 10; k++) begin
            check("stall_in_ready", 8'(in_ready), 8'd0);
            check("stall_out_valid", 8'(out_valid), 8'd1);
            check("stall_data", mul2acc, q[0]);
            cycle();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 8'(in_ready), 8'd1);
        cycle();
        drain();

        // Reset with operations in flight
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, W'($urandom_range(1, 15)), W'($urandom_range(1, 15)), 1'b0);
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 8'(out_valid), 8'd0);
        check("midrst_mul2acc", mul2acc, 8'h00);
        q.delete();
        modelAcc = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) cnt++;
            cycle();
        end
        check("no_stale", 8'(cnt), 8'd0);

`ifdef BOOTHMUL_ACC_EN
        // Accumulator chain, unsigned
        drive(1'b0, 4'd3, 4'd4, 1'b0);
        cycle();
        drive(1'b0, 4'd2, 4'd5, 1'b1);
        cycle();
        drive(1'b0, 4'd15, 4'd15, 1'b1);
        cycle();
        in_valid = 1'b0;
        in_acc   = 1'b0;
        waitValid("acc_wait");
        check("acc_first", mul2acc, 8'h0C);
        cycle();
        check("acc_second", mul2acc, 8'h16);
        cycle();
        check("acc_third", mul2acc, 8'hF7);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
